pbus_master: RTL and testbench

// - APB-like on-chip-bus initiator: turns single register-access commands into pbus SETUP/ACCESS cycles

---
 rtl/pbus_master_pkg.sv | 14 +
 rtl/pbus_master.sv | 172 +++++++++++++++++
 tb/tb_pbus_master.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbus_master_pkg.sv
// pbus_master_pkg: state encoding and small helpers shared by the pbus initiator.
package pbus_master_pkg;

   typedef enum logic [1:0] {
      PBM_IDLE   = 2'd0,
      PBM_SETUP  = 2'd1,
      PBM_ACCESS = 2'd2
   } pbm_state_e;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pbus_master.sv
// pbus_master: APB-style initiator turning single commands into pbus SETUP/ACCESS cycles.
// Optional ACCESS-phase timeout abort is built in when PBUS_TIMEOUT_EN is defined.
module pbus_master
   import pbus_master_pkg::*;
#(
   parameter int TIMEOUT_CYC = 256,
   parameter int TO_W        = 8
) (
   input  logic        pbus_clk,
   input  logic        pbus_rst,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_write_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        rsp_timeout_o,
   output logic [31:0] pbus_addr_o,
   output logic        pbus_write_o,
   output logic        pbus_sel_o,
   output logic        pbus_enable_o,
   output logic [31:0] pbus_wdata_o,
   input  logic [31:0] pbus_rdata_i,
   input  logic        pbus_ready_i,
   input  logic        pbus_slverr_i
);

   pbm_state_e  state_r, state_s;
   logic [31:0] pbus_addr_r, pbus_addr_s;
   logic [31:0] pbus_wdata_r, pbus_wdata_s;
   logic        pbus_write_r, pbus_write_s;
   logic        pbus_sel_r, pbus_sel_s;
   logic        pbus_enable_r, pbus_enable_s;
   logic        rsp_valid_r, rsp_valid_s;
   logic [31:0] rsp_rdata_r, rsp_rdata_s;
   logic        rsp_err_r, rsp_err_s;
   logic        accept_s;

   if ((TIMEOUT_CYC < 2) || ((2 ** TO_W) < TIMEOUT_CYC)) begin : g_bad_cfg
      $error("pbus_master: TIMEOUT_CYC must be >= 2 and fit in TO_W bits");
   end

`ifdef PBUS_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_r, to_cnt_s;
   logic            rsp_timeout_r, rsp_timeout_s;
   assign rsp_timeout_o = rsp_timeout_r;
`else
   assign rsp_timeout_o = 1'b0;
`endif

   assign cmd_ready_o   = (state_r == PBM_IDLE) & ~pbus_rst;
   assign accept_s      = cmd_valid_i & cmd_ready_o;
   assign pbus_addr_o   = pbus_addr_r;
   assign pbus_wdata_o  = pbus_wdata_r;
   assign pbus_write_o  = pbus_write_r;
   assign pbus_sel_o    = pbus_sel_r;
   assign pbus_enable_o = pbus_enable_r;
   assign rsp_valid_o   = rsp_valid_r;
   assign rsp_rdata_o   = rsp_rdata_r;
   assign rsp_err_o     = rsp_err_r;

   // Next-state and next-output logic of the SETUP/ACCESS sequencer
   always_comb begin
      state_s       = state_r;
      pbus_addr_s   = pbus_addr_r;
      pbus_wdata_s  = pbus_wdata_r;
      pbus_write_s  = pbus_write_r;
      pbus_sel_s    = pbus_sel_r;
      pbus_enable_s = pbus_enable_r;
      rsp_valid_s   = 1'b0;
      rsp_rdata_s   = 32'h0000_0000;
      rsp_err_s     = 1'b0;
`ifdef PBUS_TIMEOUT_EN
      to_cnt_s      = to_cnt_r;
      rsp_timeout_s = 1'b0;
`endif
      case (state_r)
         PBM_IDLE: begin
            if (accept_s) begin
               if (is_word_aligned(cmd_addr_i)) begin
                  pbus_addr_s   = cmd_addr_i;
                  pbus_wdata_s  = cmd_wdata_i;
                  pbus_write_s  = cmd_write_i;
                  pbus_sel_s    = 1'b1;
                  pbus_enable_s = 1'b0;
                  state_s       = PBM_SETUP;
               end else begin
                  // Misaligned: answer immediately without touching the bus
                  rsp_valid_s = 1'b1;
                  rsp_err_s   = 1'b1;
               end
            end else begin
               state_s = PBM_IDLE;
            end
         end
         PBM_SETUP: begin
            pbus_enable_s = 1'b1;
            state_s       = PBM_ACCESS;
`ifdef PBUS_TIMEOUT_EN
            to_cnt_s      = {TO_W{1'b0}};
`endif
         end
         PBM_ACCESS: begin
            if (pbus_ready_i) begin
               pbus_sel_s    = 1'b0;
               pbus_enable_s = 1'b0;
               rsp_valid_s   = 1'b1;
               rsp_err_s     = pbus_slverr_i;
               rsp_rdata_s   = (~pbus_write_r & ~pbus_slverr_i) ? pbus_rdata_i : 32'h0000_0000;
               state_s       = PBM_IDLE;
            end
`ifdef PBUS_TIMEOUT_EN
            else if (to_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
               pbus_sel_s    = 1'b0;
               pbus_enable_s = 1'b0;
               rsp_valid_s   = 1'b1;
               rsp_err_s     = 1'b1;
               rsp_timeout_s = 1'b1;
               state_s       = PBM_IDLE;
            end else begin
               to_cnt_s = to_cnt_r + TO_W'(1);
            end
`else
            else begin
               state_s = PBM_ACCESS;
            end
`endif
         end
         default: begin
            pbus_sel_s    = 1'b0;
            pbus_enable_s = 1'b0;
            state_s       = PBM_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops any pending response
   always_ff @(posedge pbus_clk) begin
      if (pbus_rst) begin
         state_r       <= PBM_IDLE;
         pbus_addr_r   <= 32'h0000_0000;
         pbus_wdata_r  <= 32'h0000_0000;
         pbus_write_r  <= 1'b0;
         pbus_sel_r    <= 1'b0;
         pbus_enable_r <= 1'b0;
         rsp_valid_r   <= 1'b0;
         rsp_rdata_r   <= 32'h0000_0000;
         rsp_err_r     <= 1'b0;
`ifdef PBUS_TIMEOUT_EN
         to_cnt_r      <= {TO_W{1'b0}};
         rsp_timeout_r <= 1'b0;
`endif
      end else begin
         state_r       <= state_s;
         pbus_addr_r   <= pbus_addr_s;
         pbus_wdata_r  <= pbus_wdata_s;
         pbus_write_r  <= pbus_write_s;
         pbus_sel_r    <= pbus_sel_s;
         pbus_enable_r <= pbus_enable_s;
         rsp_valid_r   <= rsp_valid_s;
         rsp_rdata_r   <= rsp_rdata_s;
         rsp_err_r     <= rsp_err_s;
`ifdef PBUS_TIMEOUT_EN
         to_cnt_r      <= to_cnt_s;
         rsp_timeout_r <= rsp_timeout_s;
`endif
      end
   end

endmodule

// File: tb/tb_pbus_master.sv
// tb_pbus_master: table-driven and hand-sequenced checks of pbus_master with a response scoreboard.
// Timeout scenarios are exercised only when PBUS_TIMEOUT_EN is defined.
module tb_pbus_master;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wait_st;
      logic [31:0] sl_rdata;
      logic        sl_err;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } rsp_t;

   logic        pbus_clk = 1'b0;
   logic        pbus_rst;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic [31:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic [31:0] pbus_addr_o;
   logic        pbus_write_o;
   logic        pbus_sel_o;
   logic        pbus_enable_o;
   logic [31:0] pbus_wdata_o;
   logic [31:0] pbus_rdata_i;
   logic        pbus_ready_i;
   logic        pbus_slverr_i;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          wcnt = 0;
   int          sl_wait = 0;
   logic [31:0] sl_rdata = 32'h0;
   logic        sl_err = 1'b0;
   logic        sl_addr_data = 1'b0;
   rsp_t        sb[$];
   vec_t        vec[8];

   pbus_master #(.TIMEOUT_CYC(8), .TO_W(3)) dut (
      .pbus_clk(pbus_clk), .pbus_rst(pbus_rst),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .rsp_timeout_o(rsp_timeout_o),
      .pbus_addr_o(pbus_addr_o), .pbus_write_o(pbus_write_o), .pbus_sel_o(pbus_sel_o),
      .pbus_enable_o(pbus_enable_o), .pbus_wdata_o(pbus_wdata_o),
      .pbus_rdata_i(pbus_rdata_i), .pbus_ready_i(pbus_ready_i), .pbus_slverr_i(pbus_slverr_i)
   );

   always #5 pbus_clk = ~pbus_clk;

   always @(posedge pbus_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Slave model: ready after sl_wait stalled ACCESS cycles
   always @(negedge pbus_clk) begin
      if (pbus_sel_o && pbus_enable_o && (wcnt >= sl_wait)) begin
         pbus_ready_i  <= 1'b1;
         pbus_rdata_i  <= sl_addr_data ? {pbus_addr_o[15:0], 16'hBEEF} : sl_rdata;
         pbus_slverr_i <= sl_err;
      end else begin
         pbus_ready_i  <= 1'b0;
         pbus_rdata_i  <= 32'h0;
         pbus_slverr_i <= 1'b0;
         wcnt          <= (pbus_sel_o && pbus_enable_o) ? wcnt + 1 : 0;
      end
   end

   // Response monitor: every rsp_valid pulse must match the oldest expectation
   always @(negedge pbus_clk) begin
      if (rsp_valid_o) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid_o), 32'h0);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata_o, e.rdata);
            chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
            chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e.to));
         end
      end
   end

   task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic e_err, input logic [31:0] e_rdata, input logic e_to);
      int   t;
      rsp_t r;
      t = 0;
      @(negedge pbus_clk);
      cmd_valid_i = 1'b1;
      cmd_write_i = w;
      cmd_addr_i  = a;
      cmd_wdata_i = d;
      #1;
      while (!cmd_ready_o && t < 50) begin
         @(negedge pbus_clk);
         #1;
         t++;
      end
      if (!cmd_ready_o) begin
         chk("accept_timeout", 32'(cmd_ready_o), 32'h1);
         cmd_valid_i = 1'b0;
      end else begin
         r.rdata = e_rdata;
         r.err   = e_err;
         r.to    = e_to;
         sb.push_back(r);
         @(posedge pbus_clk);
         #1;
         cmd_valid_i = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 2000) begin
         @(negedge pbus_clk);
         #1;
         t++;
      end
      if (sb.size() != 0) begin
         chk("rsp_missing", 32'(sb.size()), 32'h0);
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc_t[4];
      logic seen;

      vec[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
      vec[1] = '{1'b0, 32'h0000_0020, 32'h0,         0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D};
      vec[2] = '{1'b0, 32'h0000_00FC, 32'h0,         0, 32'h1111_2222, 1'b1, 1'b1, 32'h0};
      vec[3] = '{1'b1, 32'h0000_0013, 32'h5555_AAAA, 0, 32'h0,         1'b0, 1'b1, 32'h0};
      vec[4] = '{1'b0, 32'h1234_5602, 32'h0,         0, 32'h7777_7777, 1'b0, 1'b1, 32'h0};
      vec[5] = '{1'b0, 32'h0000_0040, 32'h0,         2, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'h0BAD_C0DE};
      vec[6] = '{1'b1, 32'h0000_0044, 32'h0F0F_F0F0, 1, 32'h9999_9999, 1'b1, 1'b1, 32'h0};
      vec[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         5, 32'hFFFF_0000, 1'b0, 1'b0, 32'hFFFF_0000};

      pbus_rst    = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 32'h0;
      cmd_wdata_i = 32'h0;
      repeat (3) @(posedge pbus_clk);
      @(negedge pbus_clk);
      chk("rst_sel", 32'(pbus_sel_o), 32'h0);
      chk("rst_enable", 32'(pbus_enable_o), 32'h0);
      chk("rst_addr", pbus_addr_o, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'h0);
      pbus_rst = 1'b0;
      #1;
      chk("idle_cmd_ready", 32'(cmd_ready_o), 32'h1);

      // Zero-wait write: SETUP, ACCESS, then response on consecutive cycles
      sl_wait = 0;
      send_cmd(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 1'b0, 32'h0, 1'b0);
      @(negedge pbus_clk);
      chk("zw_setup_sel", 32'(pbus_sel_o), 32'h1);
      chk("zw_setup_en", 32'(pbus_enable_o), 32'h0);
      chk("zw_addr", pbus_addr_o, 32'h0000_0010);
      chk("zw_wdata", pbus_wdata_o, 32'hA5A5_5A5A);
      chk("zw_write", 32'(pbus_write_o), 32'h1);
      @(negedge pbus_clk);
      chk("zw_access_en", 32'(pbus_enable_o), 32'h1);
      chk("zw_access_rsp", 32'(rsp_valid_o), 32'h0);
      @(negedge pbus_clk);
      chk("zw_rsp_valid", 32'(rsp_valid_o), 32'h1);
      chk("zw_rsp_sel", 32'(pbus_sel_o), 32'h0);
      drain();
      chk("zw_addr_hold", pbus_addr_o, 32'h0000_0010);

      // Table of single commands
      for (int i = 0; i < 8; i++) begin
         sl_wait  = vec[i].wait_st;
         sl_rdata = vec[i].sl_rdata;
         sl_err   = vec[i].sl_err;
         send_cmd(vec[i].write, vec[i].addr, vec[i].wdata, vec[i].exp_err, vec[i].exp_rdata, 1'b0);
         @(negedge pbus_clk);
         if (vec[i].addr[1:0] == 2'b00) begin
            chk($sformatf("vec%0d_sel", i), 32'(pbus_sel_o), 32'h1);
            chk($sformatf("vec%0d_addr", i), pbus_addr_o, vec[i].addr);
            chk($sformatf("vec%0d_write", i), 32'(pbus_write_o), 32'(vec[i].write));
         end else begin
            chk($sformatf("vec%0d_mis_sel", i), 32'(pbus_sel_o), 32'h0);
            chk($sformatf("vec%0d_mis_rsp", i), 32'(rsp_valid_o), 32'h1);
         end
         drain();
      end
      sl_err = 1'b0;

      // Read with 3 wait states: bus held stable for 4 ACCESS cycles
      sl_wait  = 3;
      sl_rdata = 32'h1234_5678;
      send_cmd(1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'h1234_5678, 1'b0);
      n = 0;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge pbus_clk);
         if (pbus_sel_o && pbus_enable_o) begin
            n++;
            chk("ws_addr_stable", pbus_addr_o, 32'h0000_0100);
            chk("ws_write_stable", 32'(pbus_write_o), 32'h0);
         end
         if (rsp_valid_o) seen = 1'b1;
      end
      chk("ws_access_cycles", 32'(n), 32'd4);
      chk("ws_rsp_seen", 32'(seen), 32'h1);
      drain();

      // Back-to-back: cmd_valid held high across four commands
      sl_wait      = 0;
      sl_addr_data = 1'b1;
      @(negedge pbus_clk);
      cmd_valid_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         rsp_t r;
         int   t;
         cmd_write_i = k[0];
         cmd_addr_i  = 32'h0000_0200 + 32'(k * 4);
         cmd_wdata_i = 32'h0000_AB00 + 32'(k);
         r.rdata = k[0] ? 32'h0 : {16'h0200 + 16'(k * 4), 16'hBEEF};
         r.err   = 1'b0;
         r.to    = 1'b0;
         #1;
         t = 0;
         while (!cmd_ready_o && t < 20) begin
            @(negedge pbus_clk);
            #1;
            t++;
         end
         sb.push_back(r);
         acc_t[k] = cyc;
         @(negedge pbus_clk);
      end
      cmd_valid_i = 1'b0;
      for (int k = 1; k < 4; k++) chk($sformatf("b2b_period%0d", k), 32'(acc_t[k] - acc_t[k-1]), 32'd3);
      drain();
      sl_addr_data = 1'b0;

      // Reset during ACCESS: bus drops and the response is discarded
      sl_wait = 1000;
      send_cmd(1'b0, 32'h0000_0300, 32'h0, 1'b0, 32'h0, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge pbus_clk);
         if (pbus_sel_o && pbus_enable_o) seen = 1'b1;
      end
      chk("rstmid_reached_access", 32'(seen), 32'h1);
      pbus_rst = 1'b1;
      @(negedge pbus_clk);
      sb.delete();
      chk("rstmid_sel", 32'(pbus_sel_o), 32'h0);
      chk("rstmid_enable", 32'(pbus_enable_o), 32'h0);
      pbus_rst = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 6; t++) begin
         @(negedge pbus_clk);
         if (rsp_valid_o) seen = 1'b1;
      end
      chk("rstmid_no_rsp", 32'(seen), 32'h0);
      sl_wait = 0;

`ifdef PBUS_TIMEOUT_EN
      // Stuck slave: abort after 8 ACCESS cycles
      sl_wait = 1000;
      send_cmd(1'b0, 32'h0000_0400, 32'h0, 1'b1, 32'h0, 1'b1);
      n = 0;
      seen = 1'b0;
      for (int t = 0; t < 30 && !seen; t++) begin
         @(negedge pbus_clk);
         if (pbus_sel_o && pbus_enable_o) n++;
         if (rsp_valid_o) seen = 1'b1;
      end
      chk("to_access_cycles", 32'(n), 32'd8);
      drain();
      // Ready in the final counted cycle wins over the abort
      sl_wait  = 7;
      sl_rdata = 32'h5A5A_0007;
      send_cmd(1'b0, 32'h0000_0404, 32'h0, 1'b0, 32'h5A5A_0007, 1'b0);
      drain();
      sl_wait  = 0;
      sl_rdata = 32'h0000_0808;
      send_cmd(1'b0, 32'h0000_0408, 32'h0, 1'b0, 32'h0000_0808, 1'b0);
      drain();
`endif

      repeat (3) @(negedge pbus_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
